// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program-counter sequencer
package pc_pkg;

  typedef enum logic [0:0] {
    PC_RUN    = 1'b0,
    PC_HALTED = 1'b1
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_JR   = 3'd3,
    SEL_ERET = 3'd4,
    SEL_TRAP = 3'd5
  } next_sel_e;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_target_gen.sv
// rtl/pc_target_gen.sv - combinational pc+4, branch and jump target generation
module pc_target_gen
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [25:0]     instr_idx,
  output logic [XLEN-1:0] pcplus4,
  output logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] j_target
);

  logic [XLEN-1:0] br_offset;

  assign pcplus4   = pc + XLEN'(INSTR_BYTES);
  // imm16 sits in the low half of the 26-bit index field
  assign br_offset = {{(XLEN-18){instr_idx[15]}}, instr_idx[15:0], 2'b00};
  assign br_target = pcplus4 + br_offset;
  assign j_target  = {pcplus4[XLEN-1:28], instr_idx, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC/EPC state, next-PC priority select, stall/halt/trap
// Optional retire counter output enabled by PC_RETIRE_CNT_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 'h0000_0080,
  parameter int unsigned     CNT_W     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            pcsrc,
  input  logic            jump,
  input  logic            jr,
  input  logic            eret,
  input  logic            halt,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4,
  output logic [XLEN-1:0] epc,
  output logic            trap,
  output logic            halted
`ifdef PC_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  generate
    if (XLEN < 32 || CNT_W == 0 || TRAP_VEC[1:0] != 2'b00) begin : g_bad_cfg
      $error("pc_sequencer: invalid parameterisation");
    end
  endgenerate

  pc_state_e       state;
  next_sel_e       req_sel;
  next_sel_e       sel;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] target;
  logic            run_en;
  logic            advance;
  logic            unused_opcode;

  assign unused_opcode = ^instr[31:26];

  pc_target_gen #(.XLEN(XLEN)) u_target_gen (
    .pc        (pc),
    .instr_idx (instr[25:0]),
    .pcplus4   (pcplus4),
    .br_target (br_target),
    .j_target  (j_target)
  );

  always_comb begin
    req_sel = SEL_SEQ;
    if (eret)       req_sel = SEL_ERET;
    else if (jr)    req_sel = SEL_JR;
    else if (jump)  req_sel = SEL_J;
    else if (pcsrc) req_sel = SEL_BR;

    target = pcplus4;
    case (req_sel)
      SEL_ERET: target = epc;
      SEL_JR:   target = rs_data;
      SEL_J:    target = j_target;
      SEL_BR:   target = br_target;
      default:  target = pcplus4;
    endcase

    // only register-sourced targets (jr, eret) can land off a word boundary
    sel = (target[1:0] != 2'b00) ? SEL_TRAP : req_sel;
  end

  assign run_en  = (state == PC_RUN) && en;
  assign advance = run_en && !halt && (sel != SEL_TRAP);
  assign halted  = (state == PC_HALTED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= PC_RUN;
      pc    <= RESET_VEC;
      epc   <= '0;
      trap  <= 1'b0;
    end else begin
      trap <= 1'b0;
      if (run_en) begin
        if (halt) begin
          state <= PC_HALTED;
        end else if (sel == SEL_TRAP) begin
          pc   <= TRAP_VEC;
          epc  <= pc;
          trap <= 1'b1;
        end else begin
          pc <= target;
        end
      end
    end
  end

`ifdef PC_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)       retire_cnt <= '0;
    else if (advance) retire_cnt <= retire_cnt + CNT_W'(1);
  end
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized bench against a behavioural model
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, en, pcsrc, jump, jr, eret, halt;
  logic [31:0] instr, rs_data;

  logic [31:0] pc_a, pcplus4_a, epc_a, pc_b, pcplus4_b, epc_b;
  logic        trap_a, halted_a, trap_b, halted_b;
`ifdef PC_RETIRE_CNT_EN
  logic [31:0] cnt_a, cnt_b;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc[2], m_epc[2], m_cnt[2];
  logic        m_trap[2], m_halted[2];
  logic [31:0] m_rv[2];

  always #5 clk = ~clk;

  pc_sequencer dut_a (
    .clk(clk), .reset(reset), .en(en), .pcsrc(pcsrc), .jump(jump), .jr(jr),
    .eret(eret), .halt(halt), .instr(instr), .rs_data(rs_data),
    .pc(pc_a), .pcplus4(pcplus4_a), .epc(epc_a), .trap(trap_a), .halted(halted_a)
`ifdef PC_RETIRE_CNT_EN
    , .retire_cnt(cnt_a)
`endif
  );

  pc_sequencer #(.RESET_VEC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .reset(reset), .en(en), .pcsrc(pcsrc), .jump(jump), .jr(jr),
    .eret(eret), .halt(halt), .instr(instr), .rs_data(rs_data),
    .pc(pc_b), .pcplus4(pcplus4_b), .epc(epc_b), .trap(trap_b), .halted(halted_b)
`ifdef PC_RETIRE_CNT_EN
    , .retire_cnt(cnt_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int k);
    logic [31:0] seq, tgt;
    if (!reset) begin
      m_pc[k] = m_rv[k]; m_epc[k] = 0; m_trap[k] = 0; m_halted[k] = 0; m_cnt[k] = 0;
    end else if (m_halted[k] || !en) begin
      m_trap[k] = 0;
    end else if (halt) begin
      m_halted[k] = 1; m_trap[k] = 0;
    end else begin
      seq = m_pc[k] + 32'd4;
      if (eret)       tgt = m_epc[k];
      else if (jr)    tgt = rs_data;
      else if (jump)  tgt = (seq & 32'hF000_0000) | (instr & 32'h03FF_FFFF) * 4;
      else if (pcsrc) tgt = seq + 32'(int'($signed(instr[15:0])) * 4);
      else            tgt = seq;
      if (tgt % 4 != 0) begin
        m_epc[k] = m_pc[k]; m_pc[k] = 32'h80; m_trap[k] = 1;
      end else begin
        m_pc[k] = tgt; m_trap[k] = 0; m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("a_pc", pc_a, m_pc[0]);
    check("a_pcplus4", pcplus4_a, m_pc[0] + 32'd4);
    check("a_epc", epc_a, m_epc[0]);
    check("a_trap", 32'(trap_a), 32'(m_trap[0]));
    check("a_halted", 32'(halted_a), 32'(m_halted[0]));
    check("b_pc", pc_b, m_pc[1]);
    check("b_epc", epc_b, m_epc[1]);
    check("b_trap", 32'(trap_b), 32'(m_trap[1]));
    check("b_halted", 32'(halted_b), 32'(m_halted[1]));
`ifdef PC_RETIRE_CNT_EN
    check("a_cnt", cnt_a, m_cnt[0]);
    check("b_cnt", cnt_b, m_cnt[1]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic idle();
    reset = 1; en = 1; pcsrc = 0; jump = 0; jr = 0; eret = 0; halt = 0;
    instr = 32'h0; rs_data = 32'h0;
  endtask

  initial begin
    logic [31:0] cnt_snap;
    m_rv[0] = 32'h0000_0000;
    m_rv[1] = 32'hFFFF_FFF8;
    idle();
    reset = 0;
    tick();
    check("rst_pc", pc_a, 32'h0);
    check("rst_halted", 32'(halted_a), 32'h0);

    idle(); tick(); check("seq_pc4", pc_a, 32'h4);
    tick();         check("seq_pc8", pc_a, 32'h8);

    jump = 1; instr = 32'h0800_000A; tick(); check("jump_pc", pc_a, 32'h28);
    idle(); pcsrc = 1; instr = 32'h1000_FFFC; tick(); check("branch_pc", pc_a, 32'h1C);
    idle(); jr = 1; rs_data = 32'h100; tick(); check("jr_pc", pc_a, 32'h100);
    jump = 1; pcsrc = 1; instr = $urandom; tick(); check("jr_prio_pc", pc_a, 32'h100);

    idle(); jr = 1; rs_data = 32'h102; tick();
    check("trap_pc", pc_a, 32'h80);
    check("trap_epc", epc_a, 32'h100);
    check("trap_high", 32'(trap_a), 32'h1);
    idle(); eret = 1; tick();
    check("eret_pc", pc_a, 32'h100);
    check("trap_low", 32'(trap_a), 32'h0);

    cnt_snap = m_cnt[0];
    idle(); en = 0; jump = 1; instr = 32'h0800_0040;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc_a, 32'h100);
    end
    check("stall_cnt_model", m_cnt[0], cnt_snap);

    idle(); halt = 1; jump = 1; instr = 32'h0800_0040; tick();
    check("halt_flag", 32'(halted_a), 32'h1);
    check("halt_pc", pc_a, 32'h100);
    for (int i = 0; i < 5; i++) begin
      halt = 1'($urandom); jr = ~jr; jump = ~jump; rs_data = $urandom;
      tick();
      check("halted_pc", pc_a, 32'h100);
      check("halted_flag", 32'(halted_a), 32'h1);
    end

    idle(); reset = 0; jump = 1; tick();
    check("rst_exit_pc", pc_a, 32'h0);
    check("rst_exit_halted", 32'(halted_a), 32'h0);
    check("wrap_pc0", pc_b, 32'hFFFF_FFF8);
    idle(); tick(); check("wrap_pc1", pc_b, 32'hFFFF_FFFC);
    tick();         check("wrap_pc2", pc_b, 32'h0000_0000);

    for (int i = 0; i < 800; i++) begin
      idle();
      reset   = (m_halted[0] || m_halted[1]) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) != 0);
      en      = ($urandom_range(0, 6) != 0);
      halt    = ($urandom_range(0, 24) == 0);
      eret    = ($urandom_range(0, 9) == 0);
      jr      = ($urandom_range(0, 5) == 0);
      jump    = ($urandom_range(0, 5) == 0);
      pcsrc   = ($urandom_range(0, 3) == 0);
      instr   = $urandom;
      rs_data = $urandom;
      if ($urandom_range(0, 9) < 7) rs_data[1:0] = 2'b00;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
